i2s_serializer: RTL

- Final audio output stage. Consumes the mixed 24-bit left/right sample words and serialises them onto a 3-wire I2S bus for the external DAC.
- Owns the audio sample clock. Issues the once-per-frame next_sample strobe that paces the PSG and PCM stages.
- Frame = 64 bit clocks, 32-bit slot per channel, 24-bit two's-complement data MSB-first, standard I2S one-bit delay.
- At a 25 MHz clk with defaults, the frame rate is 25e6/512 = 48828.125 Hz.

---
 rtl/audio_pkg.sv | 14 +
 rtl/i2s_timing.sv | 43 ++++
 rtl/i2s_serializer.sv | 80 ++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path constants and types used by the PSG/PCM/mixer/I2S stages.
package audio_pkg;

    localparam int unsigned AUDIO_DATA_WIDTH = 24;
    localparam int unsigned I2S_SLOT_BITS    = 32;
    localparam int unsigned I2S_CLKS_PER_BCK = 8;
    localparam int unsigned I2S_FRAME_CLKS   = 2 * I2S_SLOT_BITS * I2S_CLKS_PER_BCK;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } i2s_slot_e;

endpackage

// File: rtl/i2s_timing.sv
// I2S frame timebase: free-running frame counter, registered bit clock and
// look-ahead strobes for the serializer datapath.
module i2s_timing
    import audio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BCK = I2S_CLKS_PER_BCK,
    parameter int unsigned SLOT_BITS    = I2S_SLOT_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         bck,
    output logic                         bck_fall,
    output logic                         latch,
    output logic [$clog2(SLOT_BITS):0]   bit_nxt
);

    localparam int unsigned PHASE_W = $clog2(CLKS_PER_BCK);
    localparam int unsigned BIT_W   = $clog2(SLOT_BITS) + 1;
    localparam int unsigned CNT_W   = PHASE_W + BIT_W;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Decode is taken from the next count so the registered outputs line up
    // with the count value they describe.
    always_comb begin
        cnt_nxt  = cnt + CNT_W'(1);
        bck_fall = (cnt_nxt[PHASE_W-1:0] == '0);
        latch    = (cnt == '1);
        bit_nxt  = cnt_nxt[CNT_W-1:PHASE_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            bck <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            bck <= cnt_nxt[PHASE_W-1];
        end
    end

endmodule

// File: rtl/i2s_serializer.sv
// Final audio output stage: latches one left/right sample pair per frame and
// serialises it onto a standard (one-bit-delayed) I2S bus.
module i2s_serializer
    import audio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BCK = I2S_CLKS_PER_BCK,
    parameter int unsigned DATA_WIDTH   = AUDIO_DATA_WIDTH,
    parameter int unsigned SLOT_BITS    = I2S_SLOT_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] left_data,
    input  logic [DATA_WIDTH-1:0] right_data,
    output logic                  next_sample,
    output logic                  i2s_lrck,
    output logic                  i2s_bck,
    output logic                  i2s_data
);

    localparam int unsigned SLOT_W = $clog2(SLOT_BITS);

    logic              bck_fall;
    logic              latch;
    logic [SLOT_W:0]   bit_nxt;
    i2s_slot_e         slot_nxt;
    logic [SLOT_W-1:0] slot_bit_nxt;
    logic              data_bit_nxt;

    logic [DATA_WIDTH-1:0] left_sr;
    logic [DATA_WIDTH-1:0] right_sr;

    i2s_timing #(
        .CLKS_PER_BCK (CLKS_PER_BCK),
        .SLOT_BITS    (SLOT_BITS)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .bck      (i2s_bck),
        .bck_fall (bck_fall),
        .latch    (latch),
        .bit_nxt  (bit_nxt)
    );

    // Slot bit 0 is the mandatory one-bck delay; bits past the word are padding.
    always_comb begin
        slot_nxt     = i2s_slot_e'(bit_nxt[SLOT_W]);
        slot_bit_nxt = bit_nxt[SLOT_W-1:0];
        data_bit_nxt = (slot_bit_nxt != '0) && (slot_bit_nxt <= SLOT_W'(DATA_WIDTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_sample <= 1'b0;
            i2s_lrck    <= 1'b0;
            i2s_data    <= 1'b0;
            left_sr     <= '0;
            right_sr    <= '0;
        end else begin
            next_sample <= latch;
            if (bck_fall) begin
                i2s_lrck <= (slot_nxt == SLOT_RIGHT);
                if (!data_bit_nxt) begin
                    i2s_data <= 1'b0;
                end else if (slot_nxt == SLOT_LEFT) begin
                    i2s_data <= left_sr[DATA_WIDTH-1];
                    left_sr  <= {left_sr[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    i2s_data <= right_sr[DATA_WIDTH-1];
                    right_sr <= {right_sr[DATA_WIDTH-2:0], 1'b0};
                end
            end
            // Latch coincides with the slot-0 bck fall, where no shift occurs.
            if (latch) begin
                left_sr  <= left_data;
                right_sr <= right_data;
            end
        end
    end

endmodule
